ifu_prefetch: RTL and testbench

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_prefetch.sv | 143 ++++++++++++++
 tb/tb_ifu_prefetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit: one-outstanding fetch FSM feeding a PC/instruction queue.
// Optional perf counters enabled by defining IFU_PREFETCH_PERF_EN.

package ifu_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] pc_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_drop
);

  localparam int AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] req_addr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [63:0] pc_mem    [QDEPTH];
  logic [31:0] instr_mem [QDEPTH];

  logic full;
  logic issue;
  logic push;
  logic pop;
  logic drop;

  // Only one request can be in flight, so an IDLE issue with a free slot
  // implicitly reserves that slot for its response.
  assign full  = (count == (AW+1)'(QDEPTH));
  assign issue = (state == IDLE) && !full && !redirect_valid && !rst;
  assign push  = (state == WAIT) && iresp.data_ok && !redirect_valid;
  assign drop  = iresp.data_ok &&
                 (((state == WAIT) && redirect_valid) || (state == DISCARD));
  assign pop   = out_valid && out_ready && !redirect_valid;

  always_comb begin
    ireq.valid = issue || (!rst && ((state == WAIT) || (state == DISCARD)));
    ireq.addr  = (state == IDLE) ? fetch_pc : req_addr;
  end

  assign out_valid = (count != '0);
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= pc_target;
          end else if (issue) begin
            req_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (iresp.data_ok) begin
            state    <= IDLE;
            fetch_pc <= redirect_valid ? pc_target : fetch_pc + 64'd4;
          end else if (redirect_valid) begin
            fetch_pc <= pc_target;
            state    <= DISCARD;
          end
        end
        DISCARD: begin
          if (redirect_valid) fetch_pc <= pc_target;
          if (iresp.data_ok)  state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= fetch_pc;
        instr_mem[wr_ptr] <= iresp.data;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop && (drop_cnt != 32'hFFFF_FFFF))  drop_cnt  <= drop_cnt + 32'd1;
    end
  end

  assign perf_fetch = fetch_cnt;
  assign perf_drop  = drop_cnt;
`else
  assign perf_fetch = '0;
  assign perf_drop  = '0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - randomized bench for ifu_prefetch against a queue-based reference model.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int          QD  = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ibus_req_t   ireq;
  ibus_resp_t  iresp = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] pc_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] perf_fetch;
  logic [31:0] perf_drop;

  always #5 clk = ~clk;

  ifu_prefetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .ireq(ireq), .iresp(iresp),
    .redirect_valid(redirect_valid), .pc_target(pc_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .perf_fetch(perf_fetch), .perf_drop(perf_drop)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // stimulus controls
  logic        rst_i = 1'b1, redir_i = 1'b0, ready_i = 1'b0;
  logic [63:0] tgt_i = '0;
  int          mem_lat = 0;
  bit          mem_rand = 1'b0;

  // bus memory
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [63:0] mem_addr = '0;
  logic [63:0] iss[$];
  logic [63:0] popped[$];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  // reference model: fetch is idle, outstanding, or discarding a stale response
  typedef struct {logic [63:0] pc; logic [31:0] ins;} ent_t;
  typedef enum {M_IDLE, M_OUT, M_DISC} mmode_t;
  ent_t        mq[$];
  mmode_t      m_mode = M_IDLE;
  logic [63:0] m_fpc = RPC;
  logic [63:0] m_raddr = RPC;
  int          m_fetch_n = 0;
  int          m_drop_n = 0;

  logic        obs_iv, obs_ov, obs_dok;
  logic [63:0] obs_ia, obs_pc;

  task automatic cycle();
    logic        e_iv;
    logic        pop;
    logic [31:0] dword;
    @(negedge clk);
    rst            = rst_i;
    redirect_valid = redir_i;
    pc_target      = tgt_i;
    out_ready      = ready_i;
    iresp.data_ok  = mem_busy && (mem_cnt == 0) && !rst_i;
    iresp.data     = mem_busy ? instr_of(mem_addr) : $urandom;
    #1;
    e_iv = !rst_i && ((m_mode != M_IDLE) || ((mq.size() < QD) && !redir_i));
    chk("ireq_valid", ireq.valid, e_iv);
    if (e_iv) chk("ireq_addr", ireq.addr, (m_mode == M_IDLE) ? m_fpc : m_raddr);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].ins);
    end
`ifdef IFU_PREFETCH_PERF_EN
    chk("perf_fetch", perf_fetch, m_fetch_n);
    chk("perf_drop", perf_drop, m_drop_n);
`else
    chk("perf_fetch", perf_fetch, 0);
    chk("perf_drop", perf_drop, 0);
`endif
    obs_iv = ireq.valid; obs_ia = ireq.addr; obs_ov = out_valid;
    obs_pc = out_pc; obs_dok = iresp.data_ok; dword = iresp.data;
    if (obs_ov && ready_i && !redir_i && !rst_i) popped.push_back(obs_pc);
    @(posedge clk);
    if (rst_i) mem_busy = 1'b0;
    else if (mem_busy) begin
      if (obs_dok) mem_busy = 1'b0;
      else mem_cnt--;
    end else if (obs_iv) begin
      mem_busy = 1'b1;
      mem_addr = obs_ia;
      mem_cnt  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      iss.push_back(obs_ia);
    end
    if (rst_i) begin
      mq.delete(); m_mode = M_IDLE; m_fpc = RPC; m_raddr = RPC;
      m_fetch_n = 0; m_drop_n = 0;
    end else begin
      pop = (mq.size() != 0) && ready_i && !redir_i;
      if (pop) void'(mq.pop_front());
      if (redir_i) mq.delete();
      case (m_mode)
        M_IDLE:
          if (redir_i) m_fpc = tgt_i;
          else if (e_iv) begin m_raddr = m_fpc; m_mode = M_OUT; end
        M_OUT:
          if (obs_dok) begin
            m_mode = M_IDLE;
            if (redir_i) begin m_drop_n++; m_fpc = tgt_i; end
            else begin
              mq.push_back('{pc: m_fpc, ins: dword});
              m_fetch_n++;
              m_fpc = m_fpc + 64'd4;
            end
          end else if (redir_i) begin m_fpc = tgt_i; m_mode = M_DISC; end
        M_DISC: begin
          if (redir_i) m_fpc = tgt_i;
          if (obs_dok) begin m_drop_n++; m_mode = M_IDLE; end
        end
      endcase
      if (mq.size() > QD) chk("model_overflow", mq.size(), QD);
    end
    redir_i = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; run(2); rst_i = 1'b0;
    iss.delete(); popped.delete();
  endtask

  initial begin
    int k;
    logic [63:0] t;

    // reset state and in-order fetch with single-cycle memory
    mem_rand = 0; mem_lat = 0; ready_i = 1'b1;
    do_reset();
    chk("rst_out_valid", obs_ov, 1'b0);
    chk("rst_ireq_valid", obs_iv, 1'b0);
    run(12);
    chk("seq_addr0", iss[0], 64'h8000_0000);
    chk("seq_addr1", iss[1], 64'h8000_0004);
    chk("seq_addr2", iss[2], 64'h8000_0008);
    chk("seq_pc0", popped[0], 64'h8000_0000);
    chk("seq_pc1", popped[1], 64'h8000_0004);
    chk("seq_pc2", popped[2], 64'h8000_0008);

    // full queue stalls fetch; one pop frees exactly one request
    ready_i = 1'b0;
    do_reset();
    run(24);
    chk("full_req_count", iss.size(), 4);
    chk("full_ireq_valid", obs_iv, 1'b0);
    ready_i = 1'b1; run(1); ready_i = 1'b0;
    run(10);
    chk("one_pop_req_count", iss.size(), 5);

    // redirect while waiting on 0x80000008
    ready_i = 1'b1; mem_lat = 2;
    do_reset();
    k = 0;
    while (!(mem_busy && mem_addr == 64'h8000_0008) && k < 50) begin cycle(); k++; end
    chk("wait_timeout_a", k < 50, 1'b1);
    redir_i = 1'b1; tgt_i = 64'h8000_1000;
    k = 0;
    do begin
      cycle();
      if (obs_iv && !obs_dok) chk("hold_addr", obs_ia, 64'h8000_0008);
      k++;
    end while (!obs_dok && k < 20);
    chk("wait_timeout_b", k < 20, 1'b1);
    run(1);
    chk("redir_next_addr", iss[iss.size()-1], 64'h8000_1000);
`ifdef IFU_PREFETCH_PERF_EN
    chk("redir_perf_drop", perf_drop, 1);
`else
    chk("redir_perf_drop", perf_drop, 0);
`endif

    // redirect coincident with data_ok
    mem_lat = 1;
    do_reset();
    k = 0;
    while (!(mem_busy && mem_cnt == 0 && iss.size() >= 2) && k < 50) begin cycle(); k++; end
    chk("wait_timeout_c", k < 50, 1'b1);
    redir_i = 1'b1; tgt_i = 64'h8000_2000;
    cycle();
    chk("coinc_dok", obs_dok, 1'b1);
    cycle();
    chk("coinc_out_valid", obs_ov, 1'b0);
    chk("coinc_next_addr", obs_ia, 64'h8000_2000);

    // reset during WAIT
    mem_lat = 3;
    do_reset();
    k = 0;
    while (!mem_busy && k < 20) begin cycle(); k++; end
    rst_i = 1'b1; cycle(); rst_i = 1'b0;
    chk("rstwait_ireq_valid", obs_iv, 1'b0);
    cycle();
    chk("rstwait_refetch_valid", obs_iv, 1'b1);
    chk("rstwait_refetch_addr", obs_ia, RPC);
    chk("rstwait_out_valid", obs_ov, 1'b0);

    // randomized traffic
    mem_rand = 1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      redir_i = ($urandom_range(0, 15) == 0);
      t = {$urandom, $urandom};
      tgt_i = t & ~64'h3;
      rst_i = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
